// File: rtl/periph_timer_bank_pkg.sv
// rtl/periph_timer_bank_pkg.sv - shared register map and control field definitions for the timer bank
//
// Purpose: register offsets, CTRL bit positions, mode encoding and the per-channel
//          register-select decode used by the top and the channel.
// Ports:   none (package).
package periph_timer_bank_pkg;

  localparam logic [7:0] OFF_TH     = 8'h00;
  localparam logic [7:0] OFF_TL     = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_PRE    = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h80;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_MODE  = 2;
  localparam int CTRL_W     = 3;

  typedef enum logic {
    MODE_AUTO    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  // One write-enable bit per channel register.
  typedef struct packed {
    logic th;
    logic tl;
    logic ctrl;
    logic pre;
  } reg_we_t;

  // Word select within a 16-byte channel window (byte offset bits [3:2]).
  function automatic reg_we_t decode_reg(input logic [1:0] word);
    reg_we_t sel;
    sel.th   = (word == OFF_TH[3:2]);
    sel.tl   = (word == OFF_TL[3:2]);
    sel.ctrl = (word == OFF_CTRL[3:2]);
    sel.pre  = (word == OFF_PRE[3:2]);
    return sel;
  endfunction

endpackage

// File: rtl/periph_timer_bank_channel.sv
// rtl/periph_timer_bank_channel.sv - one reload timer channel with prescaler and pending flag
//
// Purpose: holds TH/TL/CTRL/PRE for one channel, runs the prescaler and counter,
//          and raises pending on counter overflow.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   we                per-register write enables for this channel
//   wdata             bus write data
//   pend_clr          clear request for pending (write-1-to-clear)
//   th, tl, ctrl, pre register values for readback
//   pending           registered overflow flag
module timer_channel
  import periph_timer_bank_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  reg_we_t           we,
  input  logic [31:0]       wdata,
  input  logic              pend_clr,
  output logic [CNT_W-1:0]  th,
  output logic [CNT_W-1:0]  tl,
  output logic [CTRL_W-1:0] ctrl,
  output logic [PRE_W-1:0]  pre,
  output logic              pending
);

  logic [CNT_W-1:0]  th_q, th_d;
  logic [CNT_W-1:0]  tl_q, tl_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              pending_q, pending_d;

  logic en;
  logic pre_hit;
  logic tick;
  logic ovf;

  always_comb begin
    en      = ctrl_q[CTRL_EN];
    pre_hit = (pre_cnt_q == pre_q);
    tick    = en && pre_hit;
    // A bus write to TL in the same cycle suppresses the overflow entirely.
    ovf     = tick && (tl_q == {CNT_W{1'b1}}) && !we.tl;

    pre_cnt_d = pre_cnt_q;
    if (en) begin
      pre_cnt_d = pre_hit ? '0 : pre_cnt_q + PRE_W'(1);
    end
    if (we.pre || (we.ctrl && wdata[CTRL_EN])) begin
      pre_cnt_d = '0;
    end

    th_d = we.th ? wdata[CNT_W-1:0] : th_q;

    // On overflow TL reloads from the TH value held before any same-cycle TH write.
    tl_d = tl_q;
    if (tick) begin
      tl_d = ovf ? th_q : tl_q + CNT_W'(1);
    end
    if (we.tl) begin
      tl_d = wdata[CNT_W-1:0];
    end

    ctrl_d = ctrl_q;
    if (ovf && (mode_e'(ctrl_q[CTRL_MODE]) == MODE_ONESHOT)) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (we.ctrl) begin
      ctrl_d = wdata[CTRL_W-1:0];
    end

    pre_d = we.pre ? wdata[PRE_W-1:0] : pre_q;

    // Set has priority over a coincident clear.
    pending_d = pending_q;
    if (pend_clr) begin
      pending_d = 1'b0;
    end
    if (ovf) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q      <= '0;
      tl_q      <= '0;
      ctrl_q    <= '0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      ctrl_q    <= ctrl_d;
      pre_q     <= pre_d;
      pre_cnt_q <= pre_cnt_d;
      pending_q <= pending_d;
    end
  end

  assign th      = th_q;
  assign tl      = tl_q;
  assign ctrl    = ctrl_q;
  assign pre     = pre_q;
  assign pending = pending_q;

endmodule

// File: rtl/periph_timer_bank.sv
// rtl/periph_timer_bank.sv - bank of memory-mapped reload timers with maskable interrupts
//
// Purpose: decodes the CPU data bus into N_CH timer channels plus a shared STATUS
//          register, muxes read data and combines per-channel interrupts.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   MemRead, MemWrite    bus strobes
//   Address, Write_data  byte address and write data
//   Read_data            combinational read data, 0 on no read or miss
//   hit                  address decodes to a mapped register (combinational)
//   irq_vec              per-channel pending & irq_en
//   irqout               OR of irq_vec
module periph_timer_bank
  import periph_timer_bank_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          CNT_W     = 32,
  parameter int          PRE_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [31:0]     Address,
  input  logic [31:0]     Write_data,
  output logic [31:0]     Read_data,
  output logic            hit,
  output logic [N_CH-1:0] irq_vec,
  output logic            irqout
);

  logic [7:0]  off;
  logic        in_block;
  logic        status_hit;
  logic        ch_hit;
  logic [2:0]  ch_idx;
  reg_we_t     reg_sel;
  logic [N_CH-1:0] pending;
  logic [31:0] ch_rdata [N_CH];
  logic [31:0] rdata;

  always_comb begin
    off        = Address[7:0];
    in_block   = (Address[31:8] == BASE_ADDR[31:8]) && (Address[1:0] == 2'b00);
    status_hit = in_block && (off == OFF_STATUS);
    ch_idx     = off[6:4];
    // Channel windows occupy the lower half only; indices beyond N_CH are unmapped.
    ch_hit     = in_block && !off[7] && (32'(ch_idx) < 32'(N_CH));
    reg_sel    = decode_reg(off[3:2]);
    hit        = status_hit || ch_hit;
  end

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    logic             sel;
    reg_we_t          we_ch;
    logic [CNT_W-1:0] th_r;
    logic [CNT_W-1:0] tl_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [PRE_W-1:0] pre_r;

    assign sel   = ch_hit && (ch_idx == 3'(g));
    assign we_ch = (MemWrite && sel) ? reg_sel : '0;

    timer_channel #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (reset),
      .we       (we_ch),
      .wdata    (Write_data),
      .pend_clr (MemWrite && status_hit && Write_data[g]),
      .th       (th_r),
      .tl       (tl_r),
      .ctrl     (ctrl_r),
      .pre      (pre_r),
      .pending  (pending[g])
    );

    assign ch_rdata[g] = reg_sel.th   ? 32'(th_r)   :
                         reg_sel.tl   ? 32'(tl_r)   :
                         reg_sel.ctrl ? 32'(ctrl_r) :
                                        32'(pre_r);

    assign irq_vec[g] = pending[g] & ctrl_r[CTRL_IRQEN];
  end

  always_comb begin
    rdata = '0;
    if (status_hit) begin
      rdata = 32'(pending);
    end
    for (int i = 0; i < N_CH; i++) begin
      if (ch_hit && (ch_idx == 3'(i))) begin
        rdata = ch_rdata[i];
      end
    end
  end

  // Read data reflects register state before any write landing on this edge.
  assign Read_data = MemRead ? rdata : 32'h0;
  assign irqout    = |irq_vec;

endmodule

// File: tb/tb_periph_timer_bank.sv
// tb/tb_periph_timer_bank.sv - self-checking bench for periph_timer_bank
module tb_periph_timer_bank;

  localparam int          N_CH   = 4;
  localparam logic [31:0] BASE   = 32'h4000_0100;
  localparam logic [31:0] STATUS = 32'h4000_0180;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        mr_a = 1'b0, mw_a = 1'b0;
  logic [31:0] addr_a = '0, wd_a = '0;
  logic [31:0] rd_a;
  logic        hit_a;
  logic [N_CH-1:0] irq_vec_a;
  logic        irqout_a;

  logic        mr_b = 1'b0, mw_b = 1'b0;
  logic [31:0] addr_b = '0, wd_b = '0;
  logic [31:0] rd_b;
  logic        hit_b;
  logic [N_CH-1:0] irq_vec_b;
  logic        irqout_b;

  always #5 clk = ~clk;

  periph_timer_bank #(.N_CH(N_CH), .CNT_W(32), .PRE_W(16), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(rst_n), .MemRead(mr_a), .MemWrite(mw_a), .Address(addr_a),
    .Write_data(wd_a), .Read_data(rd_a), .hit(hit_a), .irq_vec(irq_vec_a), .irqout(irqout_a)
  );

  periph_timer_bank #(.N_CH(N_CH), .CNT_W(8), .PRE_W(16), .BASE_ADDR(BASE)) u_dut8 (
    .clk(clk), .reset(rst_n), .MemRead(mr_b), .MemWrite(mw_b), .Address(addr_b),
    .Write_data(wd_b), .Read_data(rd_b), .hit(hit_b), .irq_vec(irq_vec_b), .irqout(irqout_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 32-bit bank: registers as plain arrays, prescaler as a
  // count of enabled edges since the last restart.
  logic [31:0]     m_th   [N_CH];
  logic [31:0]     m_tl   [N_CH];
  logic [2:0]      m_ctrl [N_CH];
  logic [15:0]     m_pre  [N_CH];
  longint          m_edges[N_CH];
  logic [N_CH-1:0] m_pend;

  function automatic void m_decode(input logic [31:0] a, output bit h, output bit st,
                                   output int ch, output int r);
    longint off;
    h = 0; st = 0; ch = 0; r = 0;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    if (a[1:0] != 2'b00 || off < 0 || off > 255) return;
    if (off == 'h80) begin
      h = 1; st = 1;
    end else if (off < 16 * N_CH) begin
      h = 1; ch = int'(off / 16); r = int'((off % 16) / 4);
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    bit h, st; int ch, r;
    m_decode(a, h, st, ch, r);
    if (!h) return 32'h0;
    if (st) return 32'(m_pend);
    case (r)
      0:       return m_th[ch];
      1:       return m_tl[ch];
      2:       return 32'(m_ctrl[ch]);
      default: return 32'(m_pre[ch]);
    endcase
  endfunction

  function automatic logic [N_CH-1:0] m_irq();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = m_pend[i] & m_ctrl[i][1];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        m_th[i] = '0; m_tl[i] = '0; m_ctrl[i] = '0; m_pre[i] = '0; m_edges[i] = 0;
      end
      m_pend = '0;
    end else begin
      bit h, st, wt, tick, ovf;
      int wch, wr;
      m_decode(addr_a, h, st, wch, wr);
      for (int i = 0; i < N_CH; i++) begin
        wt   = mw_a && h && !st && (wch == i);
        tick = 0;
        if (m_ctrl[i][0]) begin
          m_edges[i]++;
          tick = (m_edges[i] % (longint'(m_pre[i]) + 1)) == 0;
        end
        ovf = tick && (m_tl[i] == 32'hFFFF_FFFF) && !(wt && wr == 1);
        if (tick) m_tl[i] = ovf ? m_th[i] : m_tl[i] + 1;
        if (mw_a && st && wd_a[i]) m_pend[i] = 1'b0;
        if (ovf) m_pend[i] = 1'b1;
        if (ovf && m_ctrl[i][2]) m_ctrl[i][0] = 1'b0;
        if (wt) begin
          case (wr)
            0: m_th[i] = wd_a;
            1: m_tl[i] = wd_a;
            2: begin m_ctrl[i] = wd_a[2:0]; if (wd_a[0]) m_edges[i] = 0; end
            default: begin m_pre[i] = wd_a[15:0]; m_edges[i] = 0; end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit h, st; int c, r;
      m_decode(addr_a, h, st, c, r);
      check("irq_vec", 32'(irq_vec_a), 32'(m_irq()));
      check("irqout", 32'(irqout_a), 32'(|m_irq()));
      check("hit", 32'(hit_a), 32'(h));
      check("read_data", rd_a, (mr_a && h) ? m_read(addr_a) : 32'h0);
    end
  end

  function automatic logic [31:0] ca(input int ch, input int off);
    return BASE + 32'(16 * ch + off);
  endfunction

  task automatic wr(input bit b, input logic [31:0] a, input logic [31:0] d);
    if (b) begin mw_b = 1; addr_b = a; wd_b = d; end
    else   begin mw_a = 1; addr_a = a; wd_a = d; end
    @(posedge clk); #1;
    mw_a = 0; mw_b = 0;
  endtask

  task automatic rd(input bit b, input logic [31:0] a, output logic [31:0] d, output logic h);
    if (b) begin mr_b = 1; addr_b = a; end
    else   begin mr_a = 1; addr_a = a; end
    @(negedge clk);
    d = b ? rd_b : rd_a;
    h = b ? hit_b : hit_a;
    @(posedge clk); #1;
    mr_a = 0; mr_b = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    logic [31:0] miss [3];
    miss[0] = BASE + 32'h40;
    miss[1] = BASE + 32'h02;
    miss[2] = BASE + 32'h84;

    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    started = 1;

    // Reset state
    check("rst_irqout", 32'(irqout_a), 32'h0);
    check("rst_irq_vec", 32'(irq_vec_a), 32'h0);
    rd(0, ca(0, 0), d, h); check("rst_th0", d, 32'h0); check("rst_th0_hit", 32'(h), 32'h1);
    rd(0, STATUS, d, h);   check("rst_status", d, 32'h0);

    // 1: ch0 overflows on the second tick, auto-reloads, W1C clears interrupt
    wr(0, ca(0, 0), 32'hFFFF_FFF0);
    wr(0, ca(0, 4), 32'hFFFF_FFFE);
    wr(0, ca(0, 12), 32'h0);
    wr(0, ca(0, 8), 32'h3);
    cycles(2);
    rd(0, ca(0, 4), d, h); check("t1_tl_reload", d, 32'hFFFF_FFF0);
    rd(0, STATUS, d, h);   check("t1_status", d, 32'h1);
    check("t1_irqout", 32'(irqout_a), 32'h1);
    wr(0, STATUS, 32'h1);
    check("t1_irqout_clr", 32'(irqout_a), 32'h0);
    wr(0, ca(0, 8), 32'h0);

    // 2: ch1 one-shot with PRE=3 overflows after exactly 16 cycles
    wr(0, ca(1, 12), 32'h3);
    wr(0, ca(1, 4), 32'hFFFF_FFFC);
    wr(0, ca(1, 8), 32'h5);
    cycles(15);
    rd(0, STATUS, d, h);   check("t2_status_early", d, 32'h0);
    rd(0, ca(1, 8), d, h); check("t2_ctrl_oneshot", d, 32'h4);
    rd(0, STATUS, d, h);   check("t2_status", d, 32'h2);
    check("t2_irq_vec1", 32'(irq_vec_a[1]), 32'h0);
    rd(0, ca(1, 4), d, h); check("t2_tl_th", d, 32'h0);

    // 3a: overflow and W1C on the same bit in the same cycle
    wr(0, ca(2, 0), 32'h100);
    wr(0, ca(2, 4), 32'hFFFF_FFFF);
    wr(0, ca(2, 12), 32'h0);
    wr(0, ca(2, 8), 32'h3);
    wr(0, STATUS, 32'h4);
    rd(0, STATUS, d, h);   check("t3_set_wins", d, 32'h6);
    check("t3_irq_vec", 32'(irq_vec_a), 32'h4);

    // 3b: TL write coinciding with a tick at all-ones: write wins, no overflow
    wr(0, ca(3, 12), 32'h0);
    wr(0, ca(3, 8), 32'h1);
    wr(0, ca(3, 4), 32'hFFFF_FFFF);
    wr(0, ca(3, 4), 32'h5);
    rd(0, ca(3, 4), d, h); check("t3_tl_write_wins", d, 32'h5);
    rd(0, STATUS, d, h);   check("t3_no_ovf", d, 32'h6);
    wr(0, ca(3, 8), 32'h0);

    // Simultaneous read and write: read shows the pre-write value
    mr_a = 1; mw_a = 1; addr_a = ca(0, 0); wd_a = 32'h55;
    @(negedge clk);
    check("rw_old_value", rd_a, 32'hFFFF_FFF0);
    @(posedge clk); #1;
    mr_a = 0; mw_a = 0;
    rd(0, ca(0, 0), d, h); check("rw_new_value", d, 32'h55);

    // 4: unmapped addresses read 0 with hit=0 and ignore writes
    for (int k = 0; k < 3; k++) begin
      rd(0, miss[k], d, h);
      check("t4_miss_data", d, 32'h0);
      check("t4_miss_hit", 32'(h), 32'h0);
      wr(0, miss[k], 32'hFFFF_FFFF);
    end
    rd(0, ca(0, 0), d, h); check("t4_th0_kept", d, 32'h55);
    rd(0, STATUS, d, h);   check("t4_status_kept", d, 32'h6);
    rd(0, ca(1, 8), d, h); check("t4_ctrl1_kept", d, 32'h4);

    // 5: 8-bit counter wraps from FF to TH, upper read bits zero
    wr(1, ca(0, 0), 32'h10);
    wr(1, ca(0, 4), 32'hABCD_EFFE);
    rd(1, ca(0, 4), d, h); check("t5_tl_trunc", d, 32'h0000_00FE);
    wr(1, ca(0, 12), 32'h0);
    wr(1, ca(0, 8), 32'h1);
    cycles(2);
    rd(1, ca(0, 4), d, h); check("t5_tl_wrap", d, 32'h0000_0010); check("t5_hit", 32'(h), 32'h1);
    rd(1, STATUS, d, h);   check("t5_status", d, 32'h1);

    // 6: asynchronous reset mid-count with ch2 pending
    check("t6_irqout_before", 32'(irqout_a), 32'h1);
    #2 rst_n = 0;
    #1;
    check("t6_irqout_async", 32'(irqout_a), 32'h0);
    check("t6_irq_vec_async", 32'(irq_vec_a), 32'h0);
    rd(0, ca(2, 4), d, h); check("t6_tl_in_reset", d, 32'h0);
    rd(0, STATUS, d, h);   check("t6_status_in_reset", d, 32'h0);
    rst_n = 1;
    cycles(3);
    rd(0, ca(2, 4), d, h); check("t6_tl_idle", d, 32'h0);
    wr(0, ca(2, 8), 32'h1);
    cycles(3);
    rd(0, ca(2, 4), d, h); check("t6_tl_resume", d, 32'h3);

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
